// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: PC register, ROM enable/address, IF/ID capture.
// Handles stall, flush and branch/jump redirects; counts fetches into IF/ID.
//
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   stall           hold PC and IF/ID
//   flush           squash IF/ID
//   redirect_valid  load redirect_pc (word aligned) into PC
//   redirect_pc     redirect target
//   rom_ce          ROM enable (registered)
//   rom_addr        ROM byte address (the PC register)
//   rom_inst        combinational ROM word for rom_addr
//   if_id_pc        PC of held instruction
//   if_id_inst      held instruction, 0 when invalid
//   if_id_valid     IF/ID holds a real instruction
//   if_id_oob       held instruction came from word index >= ROM_WORDS
//   fetch_count     valid loads into IF/ID since reset
module inst_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic        if_id_oob,
  output logic [31:0] fetch_count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        oob;
  } if_id_t;

  localparam logic [29:0] OOB_LIM = 30'(ROM_WORDS);

  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic        ce;
  if_id_t      q;
  if_id_t      q_nxt;
  logic [31:0] cnt;

  // Low target bits are dropped on redirect.
  logic [1:0]  unused_lsb;
  assign unused_lsb = redirect_pc[1:0];

  // Mutually exclusive next-PC selects.
  logic pc_idle;
  logic pc_jump;
  logic pc_hold;
  logic pc_step;

  assign pc_idle = ~ce;
  assign pc_jump = ce & redirect_valid;
  assign pc_hold = ce & ~redirect_valid & stall;
  assign pc_step = ce & ~redirect_valid & ~stall;

  always_comb begin
    pc_nxt = pc;
    unique case (1'b1)
      pc_idle: pc_nxt = RESET_PC;
      pc_jump: pc_nxt = {redirect_pc[31:2], 2'b00};
      pc_hold: pc_nxt = pc;
      pc_step: pc_nxt = pc + 32'd4;
      default: pc_nxt = pc;
    endcase
  end

  // IF/ID: kill beats stall, so a flushed or
  // redirected slot always becomes a bubble.
  logic id_kill;
  logic id_hold;
  logic id_load;

  assign id_kill = flush | redirect_valid | ~ce;
  assign id_hold = ~id_kill & stall;
  assign id_load = ~id_kill & ~stall;

  always_comb begin
    q_nxt = q;
    unique case (1'b1)
      id_kill: q_nxt = '0;
      id_hold: q_nxt = q;
      id_load: begin
        q_nxt.pc    = pc;
        q_nxt.inst  = rom_inst;
        q_nxt.valid = 1'b1;
        q_nxt.oob   = (pc[31:2] >= OOB_LIM);
      end
      default: q_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= RESET_PC;
      ce  <= 1'b0;
      q   <= '0;
      cnt <= '0;
    end else begin
      pc  <= pc_nxt;
      ce  <= 1'b1;
      q   <= q_nxt;
      if (id_load)
        cnt <= cnt + 32'd1;
    end
  end

  assign rom_ce      = ce;
  assign rom_addr    = pc;
  assign if_id_pc    = q.pc;
  assign if_id_inst  = q.inst;
  assign if_id_valid = q.valid;
  assign if_id_oob   = q.oob;
  assign fetch_count = cnt;

endmodule
